// File: rtl/uart_rfifo_pkg.sv
// rtl/uart_rfifo_pkg.sv - shared UART receive FIFO constants
package uart_defines;
  localparam int UART_FIFO_REC_WIDTH = 11;
  localparam int UART_FIFO_DEPTH     = 16;
  localparam int UART_FIFO_POINTER_W = 4;
  localparam int UART_FIFO_COUNTER_W = 5;
endpackage

// File: rtl/uart_rfifo_mem.sv
// rtl/uart_rfifo_mem.sv - 16-entry register array, one write port, async read port
module uart_rfifo_mem
  import uart_defines::*;
#(
  parameter int width = UART_FIFO_REC_WIDTH
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [UART_FIFO_POINTER_W-1:0] waddr,
  input  logic [width-1:0]               wdata,
  input  logic [UART_FIFO_POINTER_W-1:0] raddr,
  output logic [width-1:0]               rdata
);
  logic [width-1:0] mem [UART_FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rfifo.sv
// rtl/uart_rfifo.sv - UART receive FIFO with per-entry line status and sticky overrun
module uart_rfifo
  import uart_defines::*;
#(
  parameter int fifo_width = UART_FIFO_REC_WIDTH
) (
  input  logic                           clk,
  input  logic                           fifo_reset,
  input  logic [fifo_width-1:0]          data_in,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           reset_status,
  output logic [fifo_width-1:0]          data_out,
  output logic [UART_FIFO_COUNTER_W-1:0] count,
  output logic                           read_empty,
  output logic                           overrun,
  output logic                           error_bit
);
  logic [UART_FIFO_POINTER_W-1:0] top, bottom;
  logic [2:0] status [UART_FIFO_DEPTH];
  logic full, empty, do_pop, do_write, lost;

  assign full  = (count == UART_FIFO_COUNTER_W'(UART_FIFO_DEPTH));
  assign empty = (count == '0);

  // A full FIFO still accepts a push when a pop frees the head slot in the same edge.
  assign do_pop   = pop && !empty;
  assign do_write = push && (!full || pop);
  assign lost     = push && full && !pop;

  uart_rfifo_mem #(.width(fifo_width)) u_mem (
    .clk   (clk),
    .we    (do_write),
    .waddr (top),
    .wdata (data_in),
    .raddr (bottom),
    .rdata (data_out)
  );

  // Status of vacated slots is zeroed so error_bit can OR the whole array.
  always_ff @(posedge clk or posedge fifo_reset) begin
    if (fifo_reset) begin
      top     <= '0;
      bottom  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < UART_FIFO_DEPTH; i++) status[i] <= '0;
    end else begin
      if (do_pop) begin
        status[bottom] <= '0;
        bottom         <= bottom + 1'b1;
      end
      if (do_write) begin
        status[top] <= data_in[2:0];
        top         <= top + 1'b1;
      end
      count <= count + UART_FIFO_COUNTER_W'(do_write) - UART_FIFO_COUNTER_W'(do_pop);
      if (lost)              overrun <= 1'b1;
      else if (reset_status) overrun <= 1'b0;
    end
  end

  always_comb begin
    error_bit = 1'b0;
    for (int i = 0; i < UART_FIFO_DEPTH; i++) error_bit = error_bit | (|status[i]);
  end

  assign read_empty = empty;
endmodule

// File: tb/tb_uart_rfifo.sv
// tb/tb_uart_rfifo.sv - randomized self-checking bench against a queue model
module tb_uart_rfifo;
  logic        clk = 1'b0;
  logic        fifo_reset = 1'b1;
  logic [10:0] data_in = '0;
  logic        push = 1'b0, pop = 1'b0, reset_status = 1'b0;
  logic [10:0] data_out;
  logic [4:0]  count;
  logic        read_empty, overrun, error_bit;

  int tests_run = 0;
  int tests_failed = 0;

  logic [10:0] model_q[$];
  logic        model_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rfifo dut (
    .clk          (clk),
    .fifo_reset   (fifo_reset),
    .data_in      (data_in),
    .push         (push),
    .pop          (pop),
    .reset_status (reset_status),
    .data_out     (data_out),
    .count        (count),
    .read_empty   (read_empty),
    .overrun      (overrun),
    .error_bit    (error_bit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic err;
    err = 1'b0;
    foreach (model_q[i]) err = err | (|model_q[i][2:0]);
    check({tag, ".count"}, 32'(count), 32'(model_q.size()));
    check({tag, ".empty"}, 32'(read_empty), 32'(model_q.size() == 0));
    check({tag, ".overrun"}, 32'(overrun), 32'(model_ovr));
    check({tag, ".error"}, 32'(error_bit), 32'(err));
    if (model_q.size() > 0) check({tag, ".data"}, 32'(data_out), 32'(model_q[0]));
  endtask

  // Drive one cycle of stimulus, clock it, then update the model and compare.
  task automatic step(input logic p, input logic q, input logic [10:0] d, input logic rs,
                      input string tag);
    logic was_full, was_empty;
    push = p; pop = q; data_in = d; reset_status = rs;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; reset_status = 1'b0;
    was_full  = (model_q.size() == 16);
    was_empty = (model_q.size() == 0);
    if (p && q && !was_empty) begin
      void'(model_q.pop_front());
      model_q.push_back(d);
    end else if (p) begin
      if (!was_full) model_q.push_back(d);
    end else if (q && !was_empty) begin
      void'(model_q.pop_front());
    end
    if (p && !q && was_full) model_ovr = 1'b1;
    else if (rs)             model_ovr = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    model_q.delete();
    model_ovr = 1'b0;
  endtask

  initial begin
    #12;
    check_all("reset");
    fifo_reset = 1'b0;
    @(posedge clk); #1;

    step(1, 0, 11'h2D0, 0, "push5a");
    check("push5a.lit", 32'(data_out), 32'h2D0);
    step(0, 1, 11'h000, 0, "pop5a");

    for (int i = 0; i < 16; i++) step(1, 0, 11'(i << 3), 0, "fill");
    step(1, 0, 11'h7F8, 0, "over17");
    check("over17.lit", 32'(overrun), 32'd1);
    step(0, 0, 11'h000, 1, "rstat");
    for (int i = 0; i < 16; i++) step(0, 1, 11'h000, 0, "drain");

    for (int i = 0; i < 16; i++) step(1, 0, 11'(i << 3), 0, "fill2");
    for (int i = 0; i < 20; i++) step(1, 1, 11'((i + 16) << 3), 0, "pp_full");
    for (int i = 0; i < 16; i++) step(0, 1, 11'h000, 0, "drain2");

    step(1, 0, 11'h008, 0, "err0");
    step(1, 0, 11'h012, 0, "err1");
    step(1, 0, 11'h018, 0, "err2");
    check("err.lit", 32'(error_bit), 32'd1);
    step(0, 1, 11'h000, 0, "errpop1");
    step(0, 1, 11'h000, 0, "errpop2");
    check("errpop2.lit", 32'(error_bit), 32'd0);
    step(0, 1, 11'h000, 0, "errpop3");

    step(0, 1, 11'h000, 0, "pop_empty");
    step(1, 1, 11'h155, 0, "pp_empty");
    check("pp_empty.lit", 32'(count), 32'd1);

    for (int i = 0; i < 4; i++) step(1, 0, 11'($urandom), 0, "pre_async");
    @(negedge clk); #2;
    fifo_reset = 1'b1;
    #1;
    model_reset();
    check_all("async");
    push = 1'b1; data_in = 11'h3FF;
    @(posedge clk); #1;
    push = 1'b0;
    check_all("during_rst");
    @(negedge clk);
    fifo_reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 600; i++) begin
      logic p, q, rs;
      logic [10:0] d;
      p  = ($urandom_range(0, 99) < 55);
      q  = ($urandom_range(0, 99) < 45);
      rs = ($urandom_range(0, 99) < 5);
      d  = 11'($urandom);
      if ($urandom_range(0, 3) != 0) d[2:0] = 3'b000;
      step(p, q, d, rs, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/uart_rfifo.md
UART_RFIFO -- requirements
Module: uart_rfifo

Interface
REQ-001 The module SHALL have one parameter: fifo_width, default 11, meaning the stored word width = {8-bit data, 3 status bits}.
REQ-002 The module SHALL use fixed depth 16, pointer width 4 and count width 5, taken from the shared package constants.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 fifo_reset  input  1  asynchronous active-high reset; clears all FIFO state.
REQ-006 data_in  input  fifo_width  word to push; [10:3] = data, [2] = break, [1] = parity error, [0] = framing error.
REQ-007 push  input  1  one-cycle write strobe.
REQ-008 pop  input  1  one-cycle read strobe.
REQ-009 reset_status  input  1  synchronous clear of the overrun flag.
REQ-010 data_out  output  fifo_width  head-of-queue word, valid whenever count>0 (show-ahead).
REQ-011 count  output  5  number of stored words, 0..16.
REQ-012 read_empty  output  1  high when count==0.
REQ-013 overrun  output  1  sticky flag: a push was lost because the FIFO was full.
REQ-014 error_bit  output  1  high when any stored word has any of status bits [2:0] set.

Function
REQ-015 Storage SHALL be a 16-entry circular buffer with 4-bit head (bottom) and tail (top) pointers that wrap from 15 to 0.
REQ-016 data_out SHALL combinationally present the entry at the head; its value is unspecified when count==0.
REQ-017 Push only, count<16: write data_in at tail, advance tail, count+1 in the same edge.
REQ-018 Push only, count==16: data_in SHALL be discarded, pointers and count SHALL be unchanged, and overrun SHALL be set to 1 at that edge.
REQ-019 Pop only, count>0: advance head, count-1.
REQ-020 Pop with count==0 SHALL be ignored with no state change.
REQ-021 Push and pop together with 0<count<=16: write at tail, advance both pointers, count unchanged, no overrun (full case included).
REQ-022 Push and pop together with count==0: only the push SHALL take effect (count becomes 1).
REQ-023 overrun SHALL stay 1 until cleared by reset_status=1 or fifo_reset.
REQ-024 If reset_status and an overrunning push occur in the same cycle, overrun SHALL end at 1 (set wins).
REQ-025 error_bit SHALL be the OR of bits [2:0] over exactly the valid entries (head..tail-1), evaluated combinationally from current state.
REQ-026 error_bit SHALL drop in the cycle after the last erroneous entry is popped.
REQ-027 read_empty SHALL equal (count==0) combinationally.
REQ-028 All outputs SHALL be glitch-free, registered-state derived; the only combinational path from inputs is none (outputs depend on state only).

Reset
REQ-029 fifo_reset=1 SHALL asynchronously force head=0, tail=0, count=0, overrun=0, all per-entry valid/status information cleared, error_bit=0 and read_empty=1.
REQ-030 fifo_reset asserted mid-operation SHALL discard all contents; push/pop during reset SHALL be ignored.
REQ-031 Storage data contents need not be reset.

Structure
REQ-032 Constants UART_FIFO_REC_WIDTH=11, UART_FIFO_DEPTH=16, UART_FIFO_POINTER_W=4 and UART_FIFO_COUNTER_W=5 SHALL live in the shared uart_defines package.
REQ-033 One optional sub-module, uart_rfifo_mem (16 x width register array, write port plus asynchronous read port), MAY hold data; status bits and flags SHALL remain in uart_rfifo.

Verification
REQ-034 Reset, then push 0x5A<<3 -> count=1, read_empty=0, data_out=0x2D0, error_bit=0; pop -> count=0, read_empty=1.
REQ-035 Push 16 words 0..15 (shifted <<3) -> count=16; a 17th push -> overrun=1, count=16; pop sequence returns 0..15 in order.
REQ-036 With 16 stored words, push+pop together -> count=16, overrun unchanged (0); wrap-around order is preserved.
REQ-037 Push words with status 3'b000, 3'b010 and 3'b000 -> error_bit=1; pop twice -> error_bit=0 one cycle after the second pop.
REQ-038 With overrun=1, pulse reset_status -> overrun=0; with count=5, assert fifo_reset asynchronously between edges -> count=0 immediately.
REQ-039 Pop on empty, and push+pop on empty -> count stays 0 for the pop alone and becomes 1 for the combined push+pop.
